// File: rtl/local_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : local_bus_arbiter
// Description : Two-master round-robin arbiter for the SoC local bus using the
//               FemtoRV32 rstrb/wmask + rbusy/wbusy handshake. Requests are
//               latched per master, one access is issued at a time, and a
//               hung slave is turned into an error completion by a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module local_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_rbusy,
  output logic        m0_wbusy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_rbusy,
  output logic        m1_wbusy,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_rstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_done,
  output logic        grant,
  output logic        busy_bus,
  output logic        err
);

  localparam logic [1:0]  c_st_idle      = 2'd0;
  localparam logic [1:0]  c_st_issue     = 2'd1;
  localparam logic [1:0]  c_st_wait      = 2'd2;
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] c_count_max    = 16'hFFFF;

  logic [1:0]  r_state;
  logic [1:0]  r_pending;
  logic [31:0] r_slot_addr  [2];
  logic [31:0] r_slot_wdata [2];
  logic [3:0]  r_slot_wmask [2];
  logic        r_grant;
  logic        r_last_grant;
  logic [31:0] r_s_addr;
  logic [31:0] r_s_wdata;
  logic [3:0]  r_s_wmask;
  logic [15:0] r_count;
  logic [31:0] r_rdata [2];
  logic        r_err;

  logic [31:0] w_m_addr  [2];
  logic [31:0] w_m_wdata [2];
  logic [3:0]  w_m_wmask [2];
  logic [1:0]  w_m_rstrb;
  logic [1:0]  w_strobe;
  logic [1:0]  w_cap;
  logic [1:0]  w_req;
  logic [1:0]  w_rbusy;
  logic [1:0]  w_wbusy;
  logic        w_complete;
  logic        w_timeout;
  logic        w_next_grant;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_wmask;

  assign w_m_addr[0]  = m0_addr;
  assign w_m_addr[1]  = m1_addr;
  assign w_m_wdata[0] = m0_wdata;
  assign w_m_wdata[1] = m1_wdata;
  assign w_m_wmask[0] = m0_wmask;
  assign w_m_wmask[1] = m1_wmask;
  assign w_m_rstrb    = {m1_rstrb, m0_rstrb};

  // Completion of the current access: slave done, or the WAIT budget ran out.
  always_comb begin
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      c_st_issue: w_complete = s_done;
      c_st_wait: begin
        w_timeout  = ~s_done & (r_count == c_timeout_last);
        w_complete = s_done | w_timeout;
      end
      default: ;
    endcase
  end

  // Per-master capture and busy; a slot frees up in its completion cycle so a
  // same-cycle re-strobe is captured without a busy gap.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_strobe[n] = w_m_rstrb[n] | (|w_m_wmask[n]);
      w_cap[n]    = w_strobe[n] & (~r_pending[n] | (w_complete & (r_grant == 1'(n))));
      w_req[n]    = r_pending[n] | w_cap[n];
      w_rbusy[n]  = (w_m_rstrb[n] & ~(|w_m_wmask[n]) & ~r_pending[n])
                  | (r_pending[n] & ~(|r_slot_wmask[n]));
      w_wbusy[n]  = ((|w_m_wmask[n]) & ~r_pending[n])
                  | (r_pending[n] & (|r_slot_wmask[n]));
    end
  end

  // Round-robin pick; a request strobed this cycle bypasses its slot so the
  // bus is issued the very next cycle.
  always_comb begin
    w_next_grant = (&w_req) ? ~r_last_grant : w_req[1];
    w_sel_addr   = r_pending[w_next_grant] ? r_slot_addr[w_next_grant]  : w_m_addr[w_next_grant];
    w_sel_wdata  = r_pending[w_next_grant] ? r_slot_wdata[w_next_grant] : w_m_wdata[w_next_grant];
    w_sel_wmask  = r_pending[w_next_grant] ? r_slot_wmask[w_next_grant] : w_m_wmask[w_next_grant];
  end

  // Request slots: completion clears, capture sets (capture wins).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        r_slot_addr[n]  <= 32'h0;
        r_slot_wdata[n] <= 32'h0;
        r_slot_wmask[n] <= 4'h0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_complete && (r_grant == 1'(n))) r_pending[n] <= 1'b0;
        if (w_cap[n]) begin
          r_pending[n]    <= 1'b1;
          r_slot_addr[n]  <= w_m_addr[n];
          r_slot_wdata[n] <= w_m_wdata[n];
          r_slot_wmask[n] <= w_m_wmask[n];
        end
      end
    end
  end

  // Bus FSM, timeout counter, read-data return and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_st_idle;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_s_addr     <= 32'h0;
      r_s_wdata    <= 32'h0;
      r_s_wmask    <= 4'h0;
      r_count      <= 16'h0;
      r_err        <= 1'b0;
      r_rdata[0]   <= 32'h0;
      r_rdata[1]   <= 32'h0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (|w_req) begin
            r_grant   <= w_next_grant;
            r_s_addr  <= w_sel_addr;
            r_s_wdata <= w_sel_wdata;
            r_s_wmask <= w_sel_wmask;
            r_state   <= c_st_issue;
          end
        end
        c_st_issue: begin
          r_count <= 16'h0;
          r_state <= s_done ? c_st_idle : c_st_wait;
        end
        c_st_wait: begin
          if (w_complete) r_state <= c_st_idle;
          else if (r_count != c_count_max) r_count <= r_count + 16'h1;
        end
        default: r_state <= c_st_idle;
      endcase
      if (w_complete) begin
        r_last_grant <= r_grant;
        if (r_s_wmask == 4'h0) r_rdata[r_grant] <= w_timeout ? ERR_RDATA : s_rdata;
        if (w_timeout) r_err <= 1'b1;
      end
    end
  end

  assign s_addr   = r_s_addr;
  assign s_wdata  = r_s_wdata;
  assign s_wmask  = (r_state == c_st_issue) ? r_s_wmask : 4'h0;
  assign s_rstrb  = (r_state == c_st_issue) & (r_s_wmask == 4'h0);
  assign grant    = r_grant;
  assign busy_bus = (r_state != c_st_idle);
  assign err      = r_err;
  assign m0_rdata = r_rdata[0];
  assign m1_rdata = r_rdata[1];
  assign m0_rbusy = w_rbusy[0];
  assign m1_rbusy = w_rbusy[1];
  assign m0_wbusy = w_wbusy[0];
  assign m1_wbusy = w_wbusy[1];

endmodule
`default_nettype wire

// File: tb/tb_local_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_local_bus_arbiter
// Description : Self-checking bench for local_bus_arbiter: transaction-level
//               reference model compared every cycle, plus directed scenarios
//               with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_local_bus_arbiter;

  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset_n;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_rstrb, m1_rstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb, s_done, grant, busy_bus, err;

  int n_checks = 0;
  int n_err    = 0;
  int slave_mode = 0;   // 0: done one cycle after strobe, 1: done in ISSUE, 2: never, 3: always
  bit issue_seen = 1'b0;
  bit cmp_en     = 1'b0;

  // reference model state
  bit          mo [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  mm [2];
  bit          m_active;
  int          m_age, m_owner, m_last;
  logic [31:0] m_bus_addr, m_bus_wdata;
  logic [3:0]  m_bus_mask;
  logic [31:0] m_rdata [2];
  bit          m_err;

  local_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_done(s_done),
    .grant(grant), .busy_bus(busy_bus), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      mo[n] = 1'b0; ma[n] = '0; mw[n] = '0; mm[n] = '0; m_rdata[n] = '0;
    end
    m_active = 1'b0; m_age = 0; m_owner = 0; m_last = 1;
    m_bus_addr = '0; m_bus_wdata = '0; m_bus_mask = '0; m_err = 1'b0;
  endtask

  // One clock of the arbiter's rules at transaction level.
  task automatic model_step();
    logic [31:0] ia [2];
    logic [31:0] iw [2];
    logic [3:0]  im [2];
    bit          ir [2];
    bit          acc [2];
    bit          want [2];
    bit          fin, tmo;
    int          g;
    ia[0] = m0_addr;  ia[1] = m1_addr;
    iw[0] = m0_wdata; iw[1] = m1_wdata;
    im[0] = m0_wmask; im[1] = m1_wmask;
    ir[0] = m0_rstrb; ir[1] = m1_rstrb;
    tmo = m_active && !s_done && (m_age == TMO);
    fin = m_active && (s_done || tmo);
    for (int n = 0; n < 2; n++)
      acc[n] = (ir[n] || (im[n] != 4'h0)) && (!mo[n] || (fin && m_owner == n));
    if (fin) begin
      mo[m_owner] = 1'b0;
      m_last = m_owner;
      if (m_bus_mask == 4'h0) m_rdata[m_owner] = tmo ? ERR : s_rdata;
      if (tmo) m_err = 1'b1;
      m_active = 1'b0;
    end else if (m_active) begin
      m_age++;
    end else begin
      want[0] = mo[0] || acc[0];
      want[1] = mo[1] || acc[1];
      if (want[0] || want[1]) begin
        if (want[0] && want[1]) g = 1 - m_last;
        else g = want[1] ? 1 : 0;
        m_owner = g; m_active = 1'b1; m_age = 0;
        m_bus_addr  = mo[g] ? ma[g] : ia[g];
        m_bus_wdata = mo[g] ? mw[g] : iw[g];
        m_bus_mask  = mo[g] ? mm[g] : im[g];
      end
    end
    for (int n = 0; n < 2; n++)
      if (acc[n]) begin mo[n] = 1'b1; ma[n] = ia[n]; mw[n] = iw[n]; mm[n] = im[n]; end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Slave responder.
  initial forever begin
    @(negedge clk);
    issue_seen = s_rstrb | (|s_wmask);
  end

  initial begin
    s_done = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk); #1;
      case (slave_mode)
        0: s_done = issue_seen;
        1: s_done = s_rstrb | (|s_wmask);
        3: s_done = 1'b1;
        default: s_done = 1'b0;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    wait (cmp_en);
    forever begin
      @(negedge clk);
      check("busy_bus", busy_bus, m_active);
      if (m_active) check("grant", grant, m_owner);
      check("s_addr", s_addr, m_bus_addr);
      check("s_wdata", s_wdata, m_bus_wdata);
      check("s_rstrb", s_rstrb, m_active && m_age == 0 && m_bus_mask == 4'h0);
      check("s_wmask", s_wmask, (m_active && m_age == 0) ? m_bus_mask : 4'h0);
      check("m0_rdata", m0_rdata, m_rdata[0]);
      check("m1_rdata", m1_rdata, m_rdata[1]);
      check("err", err, m_err);
      check("m0_rbusy", m0_rbusy, (m0_rstrb && m0_wmask == 0 && !mo[0]) || (mo[0] && mm[0] == 0));
      check("m0_wbusy", m0_wbusy, (m0_wmask != 0 && !mo[0]) || (mo[0] && mm[0] != 0));
      check("m1_rbusy", m1_rbusy, (m1_rstrb && m1_wmask == 0 && !mo[1]) || (mo[1] && mm[1] == 0));
      check("m1_wbusy", m1_wbusy, (m1_wmask != 0 && !mo[1]) || (mo[1] && mm[1] != 0));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_strobes();
    m0_rstrb = 1'b0; m0_wmask = 4'h0; m1_rstrb = 1'b0; m1_wmask = 4'h0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset_n = 1'b0;
    clear_strobes();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_pair();
    int wm_cycles, first_g, second_g, m0_drop, m1_drop;
    logic [31:0] wd;
    wm_cycles = 0; first_g = -1; second_g = -1; m0_drop = -1; m1_drop = -1; wd = '0;
    reset_dut(); slave_mode = 0; s_rdata = 32'hCAFE_0001;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 0) begin
        m0_addr = 32'h40; m0_rstrb = 1'b1;
        m1_addr = 32'h2000_0000; m1_wdata = 32'hA5; m1_wmask = 4'hF;
      end else clear_strobes();
      @(negedge clk);
      if (s_wmask == 4'hF) begin wm_cycles++; wd = s_wdata; end
      if (s_rstrb || s_wmask != 0) begin
        if (first_g < 0) first_g = grant; else if (second_g < 0) second_g = grant;
      end
      if (c > 0 && !m0_rbusy && m0_drop < 0) m0_drop = c;
      if (c > 0 && !m1_wbusy && m1_drop < 0) m1_drop = c;
    end
    check("t2_wmask_cycles", wm_cycles, 1);
    check("t2_wdata", wd, 32'hA5);
    check("t2_first_grant", first_g, 0);
    check("t2_second_grant", second_g, 1);
    check("t2_m0_drop", m0_drop, 3);
    check("t2_m1_drop", m1_drop, 6);
    check("t2_m0_rdata", m0_rdata, 32'hCAFE_0001);
  endtask

  task automatic test_fair();
    int ng;
    int gseq [8];
    ng = 0;
    reset_dut(); slave_mode = 0; s_rdata = 32'h0000_0F0F;
    for (int c = 0; c < 14; c++) begin
      cyc(); clear_strobes(); #1;
      if (!m0_rbusy) begin m0_addr = 32'h400 + c; m0_rstrb = 1'b1; end
      if (!m1_wbusy) begin m1_addr = 32'h800 + c; m1_wdata = c; m1_wmask = 4'hF; end
      @(negedge clk);
      if (s_rstrb || s_wmask != 0) begin
        if (ng < 8) gseq[ng] = grant;
        ng++;
      end
    end
    clear_strobes();
    check("t3_issue_count", ng, 5);
    check("t3_g0", gseq[0], 0);
    check("t3_g1", gseq[1], 1);
    check("t3_g2", gseq[2], 0);
    check("t3_g3", gseq[3], 1);
    repeat (6) cyc();
  endtask

  task automatic test_timeout();
    int drop;
    drop = -1;
    reset_dut(); slave_mode = 2;
    for (int c = 0; c < 13; c++) begin
      cyc();
      if (c == 0) begin m1_addr = 32'h300; m1_rstrb = 1'b1; end else clear_strobes();
      @(negedge clk);
      if (c == 9) check("t4_err_before", err, 0);
      if (c == 10) check("t4_rdata", m1_rdata, ERR);
      if (c > 0 && !m1_rbusy && drop < 0) drop = c;
    end
    check("t4_drop_cycle", drop, 10);
    check("t4_err", err, 1);
    slave_mode = 0; s_rdata = 32'h5555_0000;
    cyc(); m0_addr = 32'h310; m0_rstrb = 1'b1;
    cyc(); clear_strobes();
    repeat (4) cyc();
    @(negedge clk);
    check("t4_err_sticky", err, 1);
    check("t4_m0_rdata", m0_rdata, 32'h5555_0000);
  endtask

  task automatic test_reset_mid();
    reset_dut(); slave_mode = 2;
    cyc(); m0_addr = 32'h500; m0_rstrb = 1'b1; m1_addr = 32'h600; m1_wdata = 32'h1; m1_wmask = 4'h1;
    cyc(); clear_strobes();
    cyc(); @(negedge clk);
    check("t5_busy_before", busy_bus, 1);
    cyc(); reset_n = 1'b0; #1;
    check("t5_busy_bus", busy_bus, 0);
    check("t5_s_addr", s_addr, 0);
    check("t5_s_wdata", s_wdata, 0);
    check("t5_s_rstrb", s_rstrb, 0);
    check("t5_m0_rbusy", m0_rbusy, 0);
    check("t5_m1_wbusy", m1_wbusy, 0);
    check("t5_grant", grant, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t5_quiet", {busy_bus, s_rstrb, s_wmask}, 6'h0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    clear_strobes();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_busy_bus", busy_bus, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_err", err, 0);
    check("rst_s_rstrb", s_rstrb, 0);

    // single m0 read, done one cycle after strobe
    slave_mode = 0; s_rdata = 32'h1234_5678;
    cyc(); m0_addr = 32'h10; m0_rstrb = 1'b1;
    @(negedge clk); check("t1_rbusy_c0", m0_rbusy, 1);
    cyc(); clear_strobes();
    @(negedge clk); check("t1_rstrb_c1", s_rstrb, 1); check("t1_addr_c1", s_addr, 32'h10);
    cyc(); @(negedge clk); check("t1_rbusy_c2", m0_rbusy, 1);
    cyc(); @(negedge clk); check("t1_rbusy_c3", m0_rbusy, 0); check("t1_rdata_c3", m0_rdata, 32'h1234_5678);

    test_pair();
    test_fair();
    test_timeout();
    test_reset_mid();

    // second strobe while pending is ignored
    reset_dut(); slave_mode = 0; s_rdata = 32'h66;
    cyc(); m0_addr = 32'h100; m0_rstrb = 1'b1;
    cyc(); m0_addr = 32'h200;
    @(negedge clk); check("t6_addr_c1", s_addr, 32'h100); check("t6_rstrb_c1", s_rstrb, 1);
    cyc(); clear_strobes();
    for (int c = 3; c < 8; c++) begin
      cyc(); @(negedge clk);
      check("t6_no_reissue", {s_rstrb, s_addr}, {1'b0, 32'h100});
    end
    check("t6_rdata", m0_rdata, 32'h66);

    // slave completes during ISSUE
    slave_mode = 1;
    cyc(); m1_addr = 32'h700; m1_wdata = 32'h11; m1_wmask = 4'h3;
    cyc(); clear_strobes();
    @(negedge clk); check("t7_wmask_c1", s_wmask, 4'h3); check("t7_wbusy_c1", m1_wbusy, 1);
    cyc(); @(negedge clk); check("t7_wbusy_c2", m1_wbusy, 0); check("t7_busy_bus_c2", busy_bus, 0);

    // s_done held high outside an access is ignored
    slave_mode = 3; s_rdata = 32'h77;
    repeat (3) cyc();
    @(negedge clk); check("t8_idle_done", busy_bus, 0);
    cyc(); m0_addr = 32'h800; m0_rstrb = 1'b1;
    cyc(); clear_strobes();
    cyc(); @(negedge clk); check("t8_rdata", m0_rdata, 32'h77); check("t8_rbusy", m0_rbusy, 0);

    // re-strobe in the completion cycle: no busy gap
    slave_mode = 0; s_rdata = 32'h88;
    cyc(); m0_addr = 32'h900; m0_rstrb = 1'b1;
    cyc(); clear_strobes();
    cyc(); m0_addr = 32'hA00; m0_rstrb = 1'b1;
    cyc(); clear_strobes();
    @(negedge clk); check("t9_rbusy_c3", m0_rbusy, 1); check("t9_rdata_c3", m0_rdata, 32'h88);
    cyc(); @(negedge clk); check("t9_rstrb_c4", s_rstrb, 1); check("t9_addr_c4", s_addr, 32'hA00);
    repeat (4) cyc();

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
